dcache_replay_pipe: RTL and testbench

Two-stage, branch-kill-aware pipeline downstream of the data cache's branch-killable request queue. It consumes dequeued requests, issues a single-cycle-latency tag-array read, compares tags, and presents a hit/miss-tagged request to the cache's replay/refill logic. Branch mispredicts and load flushes drop in-flight entries at every stage, and branch masks are updated every cycle.

---
 rtl/dcache_replay_pipe_if.sv | 63 ++++++
 rtl/dcache_replay_pipe.sv | 165 ++++++++++++++++
 tb/tb_dcache_replay_pipe.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_replay_pipe_if.sv
// Bundle for dcache_replay_pipe: everything except clock and reset.
//   kill controls : io_flush, br_resolve_mask, br_mispredict_mask
//   request in    : in_valid/in_ready, in_addr, in_br_mask, in_uses_ldq, in_rob_idx
//   tag read      : meta_req_valid/meta_req_ready, meta_req_idx, meta_resp_tag, meta_resp_vld
//   result out    : out_valid/out_ready, out_addr, out_br_mask, out_uses_ldq, out_rob_idx, out_hit
//   status        : kill_count
// slave is the pipe itself; master is whoever drives it (queue, tag array, replay logic).
interface dcache_replay_pipe_if #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned BR_W   = 16,
  parameter int unsigned OFF_W  = 6,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W
);
  logic              io_flush;
  logic [BR_W-1:0]   br_resolve_mask;
  logic [BR_W-1:0]   br_mispredict_mask;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [BR_W-1:0]   in_br_mask;
  logic              in_uses_ldq;
  logic [6:0]        in_rob_idx;

  logic              meta_req_valid;
  logic              meta_req_ready;
  logic [IDX_W-1:0]  meta_req_idx;
  logic [TAG_W-1:0]  meta_resp_tag;
  logic              meta_resp_vld;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [BR_W-1:0]   out_br_mask;
  logic              out_uses_ldq;
  logic [6:0]        out_rob_idx;
  logic              out_hit;

  logic [7:0]        kill_count;

  modport slave (
    input  io_flush, br_resolve_mask, br_mispredict_mask,
    input  in_valid, in_addr, in_br_mask, in_uses_ldq, in_rob_idx,
    output in_ready,
    output meta_req_valid, meta_req_idx,
    input  meta_req_ready, meta_resp_tag, meta_resp_vld,
    output out_valid, out_addr, out_br_mask, out_uses_ldq, out_rob_idx, out_hit,
    input  out_ready,
    output kill_count
  );

  modport master (
    output io_flush, br_resolve_mask, br_mispredict_mask,
    output in_valid, in_addr, in_br_mask, in_uses_ldq, in_rob_idx,
    input  in_ready,
    input  meta_req_valid, meta_req_idx,
    output meta_req_ready, meta_resp_tag, meta_resp_vld,
    input  out_valid, out_addr, out_br_mask, out_uses_ldq, out_rob_idx, out_hit,
    output out_ready,
    input  kill_count
  );
endinterface

// File: rtl/dcache_replay_pipe.sv
// Two-stage branch-kill-aware pipe behind the dcache request queue.
//   S1 holds a dequeued request and issues the tag-array read; S2 compares the returned
//   tag (one cycle later) and presents the hit/miss-tagged request downstream.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : dcache_replay_pipe_if.slave (request, tag read, result, kill controls, kill_count)
module dcache_replay_pipe #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned BR_W   = 16,
  parameter int unsigned OFF_W  = 6,
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W
) (
  input logic                 clock,
  input logic                 reset,
  dcache_replay_pipe_if.slave bus
);

  // State
  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [BR_W-1:0]   r_s1_mask;
  logic              r_s1_ldq;
  logic [6:0]        r_s1_rob;

  logic              r_s2_valid;
  logic [ADDR_W-1:0] r_s2_addr;
  logic [BR_W-1:0]   r_s2_mask;
  logic              r_s2_ldq;
  logic [6:0]        r_s2_rob;
  logic              r_s2_fresh;
  logic              r_s2_hit;

  logic [7:0]        r_kill_count;

  // Next-state
  logic              w_s1_valid_d;
  logic [ADDR_W-1:0] w_s1_addr_d;
  logic [BR_W-1:0]   w_s1_mask_d;
  logic              w_s1_ldq_d;
  logic [6:0]        w_s1_rob_d;
  logic              w_s2_valid_d;
  logic [ADDR_W-1:0] w_s2_addr_d;
  logic [BR_W-1:0]   w_s2_mask_d;
  logic              w_s2_ldq_d;
  logic [6:0]        w_s2_rob_d;
  logic              w_s2_fresh_d;
  logic              w_s2_hit_d;
  logic [7:0]        w_kill_count_d;

  // Combinational control
  logic       w_in_kill, w_s1_kill, w_s2_kill;
  logic       w_s1_live, w_s2_live;
  logic       w_in_fire, w_in_load;
  logic       w_s2_free, w_meta_fire, w_out_fire;
  logic       w_hit_now;
  logic [1:0] w_kill_inc;
  logic [8:0] w_kill_sum;

  always_comb begin
    w_in_kill = ((bus.in_br_mask & bus.br_mispredict_mask) != '0) ||
                (bus.io_flush && bus.in_uses_ldq);
    w_s1_kill = r_s1_valid && (((r_s1_mask & bus.br_mispredict_mask) != '0) ||
                               (bus.io_flush && r_s1_ldq));
    w_s2_kill = r_s2_valid && (((r_s2_mask & bus.br_mispredict_mask) != '0) ||
                               (bus.io_flush && r_s2_ldq));
    w_s1_live = r_s1_valid && !w_s1_kill;
    w_s2_live = r_s2_valid && !w_s2_kill;

    w_out_fire  = w_s2_live && bus.out_ready;
    w_s2_free   = !w_s2_live || w_out_fire;
    w_meta_fire = w_s1_live && w_s2_free && bus.meta_req_ready;

    w_in_fire = bus.in_valid && (!w_s1_live || w_meta_fire);
    // A request that arrives already killed is counted but never occupies S1.
    w_in_load = w_in_fire && !w_in_kill;

    w_hit_now = bus.meta_resp_vld &&
                (bus.meta_resp_tag == r_s2_addr[ADDR_W-1:OFF_W+IDX_W]);

    w_kill_inc = 2'(w_in_fire && w_in_kill) + 2'(w_s1_kill) + 2'(w_s2_kill);
    w_kill_sum = {1'b0, r_kill_count} + {7'b0, w_kill_inc};
  end

  // Outputs
  always_comb begin
    bus.in_ready       = !w_s1_live || w_meta_fire;
    bus.meta_req_valid = w_s1_live && w_s2_free;
    bus.meta_req_idx   = r_s1_addr[OFF_W+IDX_W-1:OFF_W];
    bus.out_valid      = w_s2_live;
    bus.out_addr       = r_s2_addr;
    bus.out_br_mask    = r_s2_mask & ~bus.br_resolve_mask;
    bus.out_uses_ldq   = r_s2_ldq;
    bus.out_rob_idx    = r_s2_rob;
    // The tag response is only meaningful on the cycle right after the read fired.
    bus.out_hit        = r_s2_fresh ? w_hit_now : r_s2_hit;
    bus.kill_count     = r_kill_count;
  end

  // Next-state
  always_comb begin
    w_s1_valid_d = w_in_load || (w_s1_live && !w_meta_fire);
    w_s1_addr_d  = r_s1_addr;
    w_s1_mask_d  = r_s1_mask & ~bus.br_resolve_mask;
    w_s1_ldq_d   = r_s1_ldq;
    w_s1_rob_d   = r_s1_rob;
    if (w_in_load) begin
      w_s1_addr_d = bus.in_addr;
      w_s1_mask_d = bus.in_br_mask & ~bus.br_resolve_mask;
      w_s1_ldq_d  = bus.in_uses_ldq;
      w_s1_rob_d  = bus.in_rob_idx;
    end

    w_s2_valid_d = w_meta_fire || (w_s2_live && !w_out_fire);
    w_s2_addr_d  = r_s2_addr;
    w_s2_mask_d  = r_s2_mask & ~bus.br_resolve_mask;
    w_s2_ldq_d   = r_s2_ldq;
    w_s2_rob_d   = r_s2_rob;
    w_s2_fresh_d = 1'b0;
    w_s2_hit_d   = r_s2_fresh ? w_hit_now : r_s2_hit;
    if (w_meta_fire) begin
      w_s2_addr_d  = r_s1_addr;
      w_s2_mask_d  = r_s1_mask & ~bus.br_resolve_mask;
      w_s2_ldq_d   = r_s1_ldq;
      w_s2_rob_d   = r_s1_rob;
      w_s2_fresh_d = 1'b1;
    end

    w_kill_count_d = w_kill_sum[8] ? 8'hFF : w_kill_sum[7:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid   <= 1'b0;
      r_s1_addr    <= '0;
      r_s1_mask    <= '0;
      r_s1_ldq     <= 1'b0;
      r_s1_rob     <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_addr    <= '0;
      r_s2_mask    <= '0;
      r_s2_ldq     <= 1'b0;
      r_s2_rob     <= '0;
      r_s2_fresh   <= 1'b0;
      r_s2_hit     <= 1'b0;
      r_kill_count <= '0;
    end else begin
      r_s1_valid   <= w_s1_valid_d;
      r_s1_addr    <= w_s1_addr_d;
      r_s1_mask    <= w_s1_mask_d;
      r_s1_ldq     <= w_s1_ldq_d;
      r_s1_rob     <= w_s1_rob_d;
      r_s2_valid   <= w_s2_valid_d;
      r_s2_addr    <= w_s2_addr_d;
      r_s2_mask    <= w_s2_mask_d;
      r_s2_ldq     <= w_s2_ldq_d;
      r_s2_rob     <= w_s2_rob_d;
      r_s2_fresh   <= w_s2_fresh_d;
      r_s2_hit     <= w_s2_hit_d;
      r_kill_count <= w_kill_count_d;
    end
  end

endmodule

// File: tb/tb_dcache_replay_pipe.sv
// Bench for dcache_replay_pipe: an in-flight-entry queue model predicts the outputs every
// cycle, and directed scenarios pin both the DUT and the model to hand-computed values.
module tb_dcache_replay_pipe;
  localparam int unsigned ADDR_W = 40;
  localparam int unsigned BR_W   = 16;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned TAG_W  = 28;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dcache_replay_pipe_if #(
    .ADDR_W(ADDR_W), .BR_W(BR_W), .OFF_W(OFF_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) bus ();

  dcache_replay_pipe #(
    .ADDR_W(ADDR_W), .BR_W(BR_W), .OFF_W(OFF_W), .IDX_W(IDX_W), .TAG_W(TAG_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- model: ordered list of in-flight requests ----------------
  typedef struct {
    logic [39:0] addr;
    logic [15:0] mask;
    logic        ldq;
    logic [6:0]  rob;
    bit          issued;  // tag read done, waiting to be emitted
    bit          fresh;   // tag response arrives this cycle
    bit          hit;
  } ent_t;

  typedef struct {
    bit          in_ready, meta_valid, meta_fire, out_valid, out_fire, out_hit, hit_now;
    logic [5:0]  idx;
    logic [39:0] out_addr;
    logic [15:0] out_mask;
    logic        out_ldq;
    logic [6:0]  out_rob;
  } exp_t;

  ent_t q[$];
  int   m_kc;
  exp_t mx;

  function automatic bit doomed(ent_t e);
    return ((e.mask & bus.br_mispredict_mask) != 16'h0) || (bus.io_flush && e.ldq);
  endfunction

  function automatic exp_t model_eval();
    exp_t x;
    ent_t c, w;
    bit   has_c, has_w, c_ok, w_ok;
    x = '{default: 0};
    c = '{default: 0};
    w = '{default: 0};
    has_c = 0;
    has_w = 0;
    foreach (q[i]) begin
      if (q[i].issued) begin c = q[i]; has_c = 1; end
      else begin w = q[i]; has_w = 1; end
    end
    c_ok = has_c && !doomed(c);
    w_ok = has_w && !doomed(w);
    x.hit_now    = has_c && bus.meta_resp_vld && (bus.meta_resp_tag == c.addr[39:12]);
    x.out_valid  = c_ok;
    x.out_hit    = has_c && (c.fresh ? x.hit_now : c.hit);
    x.out_fire   = c_ok && bus.out_ready;
    x.meta_valid = w_ok && (!c_ok || x.out_fire);
    x.meta_fire  = x.meta_valid && bus.meta_req_ready;
    x.idx        = w.addr[11:6];
    x.in_ready   = !w_ok || x.meta_fire;
    x.out_addr   = c.addr;
    x.out_mask   = c.mask & ~bus.br_resolve_mask;
    x.out_ldq    = c.ldq;
    x.out_rob    = c.rob;
    return x;
  endfunction

  function automatic void model_step();
    exp_t x;
    ent_t nq[$];
    ent_t e;
    int   kills;
    x = model_eval();
    kills = 0;
    foreach (q[i]) begin
      e = q[i];
      if (doomed(e)) begin kills++; continue; end
      if (e.issued && x.out_fire) continue;
      if (e.issued && e.fresh) begin
        e.hit = x.hit_now;
        e.fresh = 0;
      end else if (!e.issued && x.meta_fire) begin
        e.issued = 1;
        e.fresh = 1;
      end
      e.mask = e.mask & ~bus.br_resolve_mask;
      nq.push_back(e);
    end
    if (bus.in_valid && x.in_ready) begin
      e = '{default: 0};
      e.addr = bus.in_addr;
      e.mask = bus.in_br_mask;
      e.ldq  = bus.in_uses_ldq;
      e.rob  = bus.in_rob_idx;
      if (doomed(e)) kills++;
      else begin
        e.mask = e.mask & ~bus.br_resolve_mask;
        nq.push_back(e);
      end
    end
    q = nq;
    m_kc = (m_kc + kills > 255) ? 255 : m_kc + kills;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_kc = 0;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Pins the DUT and the model to the same hand-computed value.
  task automatic pin(input string name, input logic [63:0] d, input logic [63:0] m,
                     input logic [63:0] lit);
    chk(name, d, lit);
    chk({name, " (model)"}, m, lit);
  endtask

  always @(negedge clock) begin
    exp_t x;
    x = model_eval();
    chk("in_ready", 64'(bus.in_ready), 64'(x.in_ready));
    chk("meta_req_valid", 64'(bus.meta_req_valid), 64'(x.meta_valid));
    chk("out_valid", 64'(bus.out_valid), 64'(x.out_valid));
    chk("kill_count", 64'(bus.kill_count), 64'(m_kc));
    if (x.meta_valid) chk("meta_req_idx", 64'(bus.meta_req_idx), 64'(x.idx));
    if (x.out_valid) begin
      chk("out_hit", 64'(bus.out_hit), 64'(x.out_hit));
      chk("out_addr", 64'(bus.out_addr), 64'(x.out_addr));
      chk("out_br_mask", 64'(bus.out_br_mask), 64'(x.out_mask));
      chk("out_uses_ldq", 64'(bus.out_uses_ldq), 64'(x.out_ldq));
      chk("out_rob_idx", 64'(bus.out_rob_idx), 64'(x.out_rob));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
    #1;
    mx = model_eval();
  endtask

  task automatic idle();
    bus.io_flush           = 1'b0;
    bus.br_resolve_mask    = '0;
    bus.br_mispredict_mask = '0;
    bus.in_valid           = 1'b0;
    bus.in_addr            = '0;
    bus.in_br_mask         = '0;
    bus.in_uses_ldq        = 1'b0;
    bus.in_rob_idx         = '0;
    bus.meta_req_ready     = 1'b1;
    bus.meta_resp_tag      = '0;
    bus.meta_resp_vld      = 1'b0;
    bus.out_ready          = 1'b1;
  endtask

  task automatic drive_in(input bit v, input logic [39:0] a, input logic [15:0] m,
                          input bit l, input logic [6:0] r);
    bus.in_valid    = v;
    bus.in_addr     = a;
    bus.in_br_mask  = m;
    bus.in_uses_ldq = l;
    bus.in_rob_idx  = r;
  endtask

  // E (S2) and F (S1) with uses_ldq held behind a stalled output, then G arrives under flush.
  task automatic flush_three();
    bus.out_ready = 1'b0;
    drive_in(1, 40'h0000002000, 16'h0, 1, 7'd40);
    step();
    drive_in(1, 40'h0000003000, 16'h0, 1, 7'd41);
    step();
    drive_in(1, 40'h0000004000, 16'h0, 1, 7'd42);
    bus.io_flush = 1'b1;
    mid();
    pin("flush out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 0);
    pin("flush meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 0);
    pin("flush in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 1);
    step();
    bus.io_flush = 1'b0;
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    idle();
    // Reset
    step();
    step();
    mid();
    pin("rst in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 1);
    pin("rst meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 0);
    pin("rst out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 0);
    chk("rst out_hit", 64'(bus.out_hit), 0);
    pin("rst kill_count", 64'(bus.kill_count), 64'(m_kc), 0);
    step();
    reset = 1'b1;
    step();

    // Single request: idx 0x1F, tag 0x0123456 hits
    drive_in(1, 40'h01234567C0, 16'h0, 0, 7'd5);
    mid();
    pin("single in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 1);
    step();
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);
    mid();
    pin("single meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 1);
    pin("single meta_req_idx", 64'(bus.meta_req_idx), 64'(mx.idx), 64'h1F);
    step();
    bus.meta_resp_tag = 28'h0123456;
    bus.meta_resp_vld = 1'b1;
    mid();
    pin("single out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 1);
    pin("single out_hit", 64'(bus.out_hit), 64'(mx.out_hit), 1);
    pin("single out_addr", 64'(bus.out_addr), 64'(mx.out_addr), 64'h01234567C0);
    step();
    bus.meta_resp_vld = 1'b0;
    mid();
    pin("single drained", 64'(bus.out_valid), 64'(mx.out_valid), 0);
    step();

    // Back-to-back: four misses, outputs on four consecutive cycles
    bus.meta_resp_tag = 28'hFFFFFFF;
    bus.meta_resp_vld = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive_in(i < 4, 40'h00000AB000 + 40'(i * 64), 16'h0, 0, 7'(i + 10));
      mid();
      if (i < 4) pin("b2b in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 1);
      pin("b2b out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 64'(i >= 2 && i < 6));
      if (i >= 2 && i < 6) pin("b2b out_hit", 64'(bus.out_hit), 64'(mx.out_hit), 0);
      step();
    end
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);

    // Stall: A hits on its fresh cycle, tag then changes; B waits in S1
    bus.out_ready = 1'b0;
    bus.meta_resp_vld = 1'b0;
    drive_in(1, 40'h00ABCDE080, 16'h0, 0, 7'd20);
    step();
    drive_in(1, 40'h0012345100, 16'h0, 0, 7'd21);
    step();
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);
    bus.meta_resp_tag = 28'h00ABCDE;
    bus.meta_resp_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      pin("stall out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 1);
      pin("stall out_hit", 64'(bus.out_hit), 64'(mx.out_hit), 1);
      pin("stall meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 0);
      pin("stall in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 0);
      pin("stall out_addr", 64'(bus.out_addr), 64'(mx.out_addr), 64'h00ABCDE080);
      step();
      bus.meta_resp_tag = 28'h1111111;
    end
    bus.out_ready = 1'b1;
    mid();
    pin("unstall meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 1);
    step();
    mid();
    pin("B out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 1);
    pin("B out_hit", 64'(bus.out_hit), 64'(mx.out_hit), 0);
    step();
    bus.meta_resp_vld = 1'b0;

    // Branch: C (mask 0x2) in S2, D (mask 0x4) in S1; resolve 0x2, then mispredict 0x4
    bus.out_ready = 1'b0;
    drive_in(1, 40'h0000001000, 16'h0002, 0, 7'd30);
    step();
    drive_in(1, 40'h0000001040, 16'h0004, 0, 7'd31);
    step();
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);
    bus.br_resolve_mask = 16'h0002;
    mid();
    pin("br resolved mask", 64'(bus.out_br_mask), 64'(mx.out_mask), 0);
    pin("br out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 1);
    step();
    bus.br_resolve_mask = 16'h0;
    bus.br_mispredict_mask = 16'h0004;
    mid();
    pin("br mispred out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 1);
    pin("br mispred meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 0);
    pin("br mispred out_br_mask", 64'(bus.out_br_mask), 64'(mx.out_mask), 0);
    step();
    bus.br_mispredict_mask = 16'h0;
    bus.out_ready = 1'b1;
    mid();
    pin("br kill_count", 64'(bus.kill_count), 64'(m_kc), 1);
    pin("br S1 dropped", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 0);
    step();
    mid();
    pin("br drained", 64'(bus.out_valid), 64'(mx.out_valid), 0);
    step();

    // Flush: three kills in one cycle
    flush_three();
    mid();
    pin("flush kill_count", 64'(bus.kill_count), 64'(m_kc), 4);
    pin("flush nothing out", 64'(bus.out_valid), 64'(mx.out_valid), 0);
    step();

    // Preload kill_count to 254 with killed incoming requests
    drive_in(1, 40'h0000005000, 16'h0, 1, 7'd50);
    bus.io_flush = 1'b1;
    repeat (250) step();
    bus.io_flush = 1'b0;
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);
    mid();
    pin("preload kill_count", 64'(bus.kill_count), 64'(m_kc), 254);
    step();
    flush_three();
    mid();
    pin("saturated kill_count", 64'(bus.kill_count), 64'(m_kc), 255);
    step();

    // Reset mid-operation with S1 and S2 occupied
    bus.out_ready = 1'b0;
    drive_in(1, 40'h0000006000, 16'h0, 0, 7'd60);
    step();
    drive_in(1, 40'h0000007000, 16'h0, 0, 7'd61);
    step();
    drive_in(0, 40'h0, 16'h0, 0, 7'd0);
    mid();
    pin("pre-rst out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 1);
    pin("pre-rst in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 0);
    step();
    reset = 1'b0;
    #1;
    mx = model_eval();
    pin("async rst out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 0);
    pin("async rst in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 1);
    pin("async rst kill_count", 64'(bus.kill_count), 64'(m_kc), 0);
    step();
    step();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      pin("post-rst out_valid", 64'(bus.out_valid), 64'(mx.out_valid), 0);
      pin("post-rst in_ready", 64'(bus.in_ready), 64'(mx.in_ready), 1);
      pin("post-rst meta_req_valid", 64'(bus.meta_req_valid), 64'(mx.meta_valid), 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "timeout");
  end

endmodule
